// File: rtl/mac_pkg.sv
// mac_pkg -- shared widths, output limits and the widened sum type for the
// MAC activation stage.
//   ACC_W / OUT_W / SHIFT_W : accumulator, activation and shift-amount widths
//   OUT_MAX / OUT_MIN       : signed saturation limits of the activation
//   sum_t                   : signed 17-bit bias-add result (cannot overflow)
//   sat_out()               : clamp a sum_t into the OUT_W signed range
package mac_pkg;
    localparam int ACC_W   = 16;
    localparam int OUT_W   = 8;
    localparam int SHIFT_W = 4;
    localparam int OUT_MAX = 127;
    localparam int OUT_MIN = -128;

    typedef logic signed [ACC_W:0] sum_t;

    function automatic logic [OUT_W-1:0] sat_out(input sum_t v);
        if (v > sum_t'(OUT_MAX))
            return OUT_W'(OUT_MAX);
        else if (v < sum_t'(OUT_MIN))
            return OUT_W'(OUT_MIN);
        else
            return v[OUT_W-1:0];
    endfunction
endpackage

// File: rtl/mac_out_fifo.sv
// mac_out_fifo -- small output buffer for activation results.
//   clk, rst   : clock, synchronous active-high reset
//   push       : write data_in (ignored when full unless a pop happens too)
//   data_in    : activation result to store
//   pop        : remove head entry (ignored when empty)
//   data_out   : head entry, 0 when empty
//   empty/full : occupancy status
// FIFO_DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module mac_out_fifo
    import mac_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [OUT_W-1:0] data_in,
    input  logic             pop,
    output logic [OUT_W-1:0] data_out,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [OUT_W-1:0] mem_q [FIFO_DEPTH];
    logic [OUT_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNT_W'(FIFO_DEPTH));

    // A pop frees the head slot in the same cycle, so a full buffer can
    // still accept a push when it is also being drained.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign data_out = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        cnt_d    = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (do_push)
            mem_d[wr_ptr_q] = data_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end
endmodule

// File: rtl/mac_act_stage.sv
// mac_act_stage -- bias add, arithmetic right shift and saturation of a MAC
// result, buffered for a ready/valid consumer.
//   clk, rst   : clock, synchronous active-high reset
//   acc_in     : signed accumulator, qualified by the acc_valid pulse
//   bias/shift : signed bias and right-shift amount sampled with acc_valid
//   out_data   : signed 8-bit activation at the buffer head
//   out_valid  : buffer non-empty; out_ready accepts the head
//   overflow   : sticky, a result was dropped because the buffer was full
// Optional macro ACT_RELU_EN: negative shifted values clamp to 0.
// Upstream is never stalled: results that find the buffer full are lost.
module mac_act_stage
    import mac_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ACC_W-1:0]   acc_in,
    input  logic               acc_valid,
    input  logic [ACC_W-1:0]   bias,
    input  logic [SHIFT_W-1:0] shift,
    output logic [OUT_W-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               overflow
);
    logic               s1_valid_q, s1_valid_d;
    sum_t               s1_sum_q, s1_sum_d;
    logic [SHIFT_W-1:0] s1_shift_q, s1_shift_d;
    logic               overflow_q, overflow_d;

    sum_t               shifted;
    sum_t               act;
    logic [OUT_W-1:0]   act_sat;
    logic               pop, full, empty;

    // Stage 1: 17-bit sum so the bias add itself can never wrap.
    always_comb begin
        s1_valid_d = acc_valid;
        s1_sum_d   = s1_sum_q;
        s1_shift_d = s1_shift_q;
        if (acc_valid) begin
            s1_sum_d   = sum_t'($signed(acc_in)) + sum_t'($signed(bias));
            s1_shift_d = shift;
        end
    end

    // Stage 2: >>> on a signed operand floors toward minus infinity.
    always_comb begin
        shifted = s1_sum_q >>> s1_shift_q;
`ifdef ACT_RELU_EN
        act = shifted[ACC_W] ? '0 : shifted;
`else
        act = shifted;
`endif
        act_sat = sat_out(act);
    end

    assign out_valid = ~empty;
    assign pop       = out_valid & out_ready;
    assign overflow  = overflow_q;

    always_comb begin
        overflow_d = overflow_q | (s1_valid_q & full & ~pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_shift_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s1_shift_q <= s1_shift_d;
            overflow_q <= overflow_d;
        end
    end

    mac_out_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (s1_valid_q),
        .data_in  (act_sat),
        .pop      (pop),
        .data_out (out_data),
        .empty    (empty),
        .full     (full)
    );
endmodule

// File: doc/mac_act_stage.md
MAC_ACT_STAGE -- requirements
Module: mac_act_stage

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, output buffer entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port acc_in  input  16  signed MAC accumulator result.
REQ-005 SHALL have port acc_valid  input  1  single-cycle pulse qualifying acc_in (driven from MAC done).
REQ-006 SHALL have port bias  input  16  signed bias, sampled with acc_valid.
REQ-007 SHALL have port shift  input  4  right-shift amount 0..15, sampled with acc_valid.
REQ-008 SHALL have port out_data  output  8  signed activation result, head of buffer.
REQ-009 SHALL have port out_valid  output  1  buffer non-empty.
REQ-010 SHALL have port out_ready  input  1  consumer accepts out_data when out_valid&out_ready.
REQ-011 SHALL have port overflow  output  1  sticky flag, result dropped because buffer full.

Function
REQ-012 SHALL have no ready toward upstream; acc_valid is never stalled.
REQ-013 Stage 1 SHALL register sum = sext17(acc_in) + sext17(bias), plus shift and a valid bit, on acc_valid.
REQ-014 Stage 2 SHALL compute sum >>> shift (arithmetic, truncation toward minus infinity), then saturate to [-128, 127].
REQ-015 Stage 2 result SHALL be pushed into the buffer one cycle after stage 1 captures; acc_valid at cycle N -> out_valid at cycle N+2 when buffer empty.
REQ-016 Back-to-back acc_valid pulses on consecutive cycles SHALL each produce one result, in order.
REQ-017 Buffer SHALL be FIFO ordered; out_data SHALL be stable while out_valid&!out_ready.
REQ-018 Pop occurs on out_valid&out_ready; push and pop in the same cycle SHALL both take effect, including when full (occupancy unchanged).
REQ-019 Push while full without a same-cycle pop SHALL discard the new result, keep buffer contents, and set overflow.
REQ-020 overflow SHALL remain 1 until rst; no other clear.
REQ-021 Pop when empty SHALL have no effect.
REQ-022 Occupancy counter SHALL span 0..FIFO_DEPTH; pointers SHALL wrap modulo FIFO_DEPTH.

Reset
REQ-023 rst SHALL set out_valid=0, out_data=0, overflow=0, occupancy and pointers 0, stage-1 valid 0.
REQ-024 rst mid-operation SHALL discard in-flight stage-1 results and all buffered data; acc_valid during rst SHALL be ignored.
REQ-025 First result accepted SHALL be from acc_valid asserted in the first cycle after rst deasserts.

Configuration
REQ-026 Macro ACT_RELU_EN SHALL, when defined, clamp negative shifted values to 0 before saturation (output range 0..127).
REQ-027 Without ACT_RELU_EN, output SHALL be plain signed saturation to [-128, 127].

Structure
REQ-028 Package mac_pkg SHALL hold ACC_W=16, OUT_W=8, SHIFT_W=4, OUT_MAX=127, OUT_MIN=-128 and the typedef for the signed 17-bit sum.
REQ-029 Buffer SHALL be a sub-module mac_out_fifo (push, data_in, pop, data_out, empty, full, parameter FIFO_DEPTH); datapath and overflow logic stay in mac_act_stage.

Verification
REQ-030 acc_in=0x0100, bias=0x0010, shift=4, out_ready=1, pulse at N -> out_data=0x11, out_valid=1 at N+2 for one cycle.
REQ-031 acc_in=0x7FFF, bias=0x7FFF, shift=0 -> out_data=0x7F (positive saturation, no wrap); acc_in=0x8000, bias=0x8000, shift=0 -> 0x80 without ACT_RELU_EN, 0x00 with.
REQ-032 acc_in=0xFF00, bias=0, shift=2 -> 0xC0 without ACT_RELU_EN, 0x00 with; acc_in=0xFFFF, shift=1 -> 0xFF (truncation toward minus infinity).
REQ-033 out_ready=0, three pulses with acc_in 1,2,3 (bias 0, shift 0) -> two entries held, overflow=1; then out_ready=1 -> out_data 0x01 then 0x02, out_valid falls, overflow stays 1.
REQ-034 Buffer full, out_ready=1 in the push cycle -> no overflow, order preserved, occupancy stays FIFO_DEPTH.
REQ-035 rst asserted one cycle after a pulse with two entries buffered -> after rst out_valid=0, overflow=0, no stale output; next pulse yields output at N+2.
